// File: rtl/image_sobel_edge_3x3.sv
// Sobel |Gx|+|Gy| edge detector: 3-stage pipeline, border suppression, per-frame edge count.
// Define SOBEL_GRAD_OUT_EN to add the post_img_grad output.
module image_sobel_edge_3x3 #(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_sof,
  input  logic        matrix_image_clken,
  input  logic [7:0]  matrix_p11,
  input  logic [7:0]  matrix_p12,
  input  logic [7:0]  matrix_p13,
  input  logic [7:0]  matrix_p21,
  input  logic [7:0]  matrix_p22,
  input  logic [7:0]  matrix_p23,
  input  logic [7:0]  matrix_p31,
  input  logic [7:0]  matrix_p32,
  input  logic [7:0]  matrix_p33,
  input  logic [10:0] sobel_threshold,
  output logic        post_image_clken,
  output logic        post_img_bit,
  output logic [7:0]  post_img_gray,
  output logic [18:0] edge_count_frame,
`ifdef SOBEL_GRAD_OUT_EN
  output logic [10:0] post_img_grad,
`endif
  output logic        frame_done
);
  localparam int STAGES = 3;

  logic [STAGES-1:0] r_vld_pipe;
  logic [9:0]  r_col, r_row, w_col, w_row;
  logic        w_col_last, w_row_last;
  logic [10:0] r_thr;
  logic [18:0] r_cnt, w_cnt_base, w_cnt_nxt;
  logic [9:0]  w_gxp, w_gxn, w_gyp, w_gyn;
  logic [9:0]  r_gxp1, r_gxn1, r_gyp1, r_gyn1, r_gx2, r_gy2;
  logic        r_bdr1, r_last1, r_bdr2, r_last2;
  logic [10:0] w_grad;
  logic        w_edge;
  logic        w_unused;

  // Sobel ignores the centre tap.
  assign w_unused = ^matrix_p22;

  // A coincident sof places the accepted pixel at (0,0).
  assign w_col      = frame_sof ? 10'd0 : r_col;
  assign w_row      = frame_sof ? 10'd0 : r_row;
  assign w_col_last = (w_col == IMG_HDISP - 10'd1);
  assign w_row_last = (w_row == IMG_VDISP - 10'd1);

  assign w_gxp = {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
  assign w_gxn = {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
  assign w_gyp = {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};
  assign w_gyn = {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};

  assign w_grad = {1'b0, r_gx2} + {1'b0, r_gy2};
  assign w_edge = (w_grad > r_thr) && !r_bdr2;

  // Edges of pixels still in flight at sof count into the new frame.
  assign w_cnt_base = frame_sof ? 19'd0 : r_cnt;
  assign w_cnt_nxt  = (r_vld_pipe[1] && w_edge && (w_cnt_base != '1)) ? w_cnt_base + 19'd1
                                                                         : w_cnt_base;

  assign post_image_clken = r_vld_pipe[STAGES-1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_vld_pipe <= '0;
    else        r_vld_pipe <= {r_vld_pipe[STAGES-2:0], matrix_image_clken};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_thr <= '0;
    else if (frame_sof) r_thr <= sobel_threshold;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (matrix_image_clken) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? 10'd0 : w_row + 10'd1;
      end else begin
        r_col <= w_col + 10'd1;
        r_row <= w_row;
      end
    end else if (frame_sof) begin
      r_col <= '0;
      r_row <= '0;
    end

  // Stage 1: weighted column/row sums; position travels as border/last flags.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_gxp1  <= '0;
      r_gxn1  <= '0;
      r_gyp1  <= '0;
      r_gyn1  <= '0;
      r_bdr1  <= 1'b0;
      r_last1 <= 1'b0;
    end else if (matrix_image_clken) begin
      r_gxp1  <= w_gxp;
      r_gxn1  <= w_gxn;
      r_gyp1  <= w_gyp;
      r_gyn1  <= w_gyn;
      r_bdr1  <= (w_col == 10'd0) || w_col_last || (w_row == 10'd0) || w_row_last;
      r_last1 <= w_col_last && w_row_last;
    end

  // Stage 2: absolute differences.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_gx2   <= '0;
      r_gy2   <= '0;
      r_bdr2  <= 1'b0;
      r_last2 <= 1'b0;
    end else if (r_vld_pipe[0]) begin
      r_gx2   <= (r_gxp1 >= r_gxn1) ? r_gxp1 - r_gxn1 : r_gxn1 - r_gxp1;
      r_gy2   <= (r_gyp1 >= r_gyn1) ? r_gyp1 - r_gyn1 : r_gyn1 - r_gyp1;
      r_bdr2  <= r_bdr1;
      r_last2 <= r_last1;
    end

  // Stage 3: threshold, outputs and frame accounting.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      post_img_bit  <= 1'b0;
      post_img_gray <= '0;
`ifdef SOBEL_GRAD_OUT_EN
      post_img_grad <= '0;
`endif
    end else if (r_vld_pipe[1]) begin
      post_img_bit  <= w_edge;
      post_img_gray <= w_edge ? 8'hFF : 8'h00;
`ifdef SOBEL_GRAD_OUT_EN
      post_img_grad <= r_bdr2 ? 11'd0 : w_grad;
`endif
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt            <= '0;
      edge_count_frame <= '0;
      frame_done       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (r_vld_pipe[1] && r_last2) begin
        edge_count_frame <= w_cnt_nxt;
        frame_done       <= 1'b1;
        r_cnt            <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end
endmodule

// File: tb/tb_image_sobel_edge_3x3.sv
// Randomized scoreboard bench for image_sobel_edge_3x3 on a reduced 16x12 frame.
module tb_image_sobel_edge_3x3;
  localparam int H = 16;
  localparam int V = 12;

  logic        clk = 1'b0, rst_n = 1'b0, frame_sof = 1'b0, clken = 1'b0;
  logic [7:0]  win [3][3];
  logic [10:0] thr = '0;
  logic        post_image_clken, post_img_bit, frame_done;
  logic [7:0]  post_img_gray;
  logic [18:0] edge_count_frame;
`ifdef SOBEL_GRAD_OUT_EN
  logic [10:0] post_img_grad;
`endif

  image_sobel_edge_3x3 #(.IMG_HDISP(10'd16), .IMG_VDISP(10'd12)) dut (
    .clk(clk), .rst_n(rst_n), .frame_sof(frame_sof), .matrix_image_clken(clken),
    .matrix_p11(win[0][0]), .matrix_p12(win[0][1]), .matrix_p13(win[0][2]),
    .matrix_p21(win[1][0]), .matrix_p22(win[1][1]), .matrix_p23(win[1][2]),
    .matrix_p31(win[2][0]), .matrix_p32(win[2][1]), .matrix_p33(win[2][2]),
    .sobel_threshold(thr), .post_image_clken(post_image_clken), .post_img_bit(post_img_bit),
    .post_img_gray(post_img_gray), .edge_count_frame(edge_count_frame),
`ifdef SOBEL_GRAD_OUT_EN
    .post_img_grad(post_img_grad),
`endif
    .frame_done(frame_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int stamp; bit b; int g; } exp_t;
  typedef struct { int stamp; int cnt; } frm_t;
  exp_t sbq[$];
  frm_t fq[$];
  int checks = 0, errors = 0;
  int m_col = 0, m_row = 0, m_cnt = 0, m_thr = 0;
  int KX[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int KY[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: convolve with the Sobel kernels, threshold, and walk the raster position.
  task automatic issue(input bit v, input bit sof);
    exp_t e;
    int gx, gy;
    bit border;
    clken = v;
    frame_sof = sof;
    if (sof) begin m_col = 0; m_row = 0; m_cnt = 0; m_thr = int'(thr); end
    if (v) begin
      gx = 0; gy = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          gx += KX[r][c] * int'(win[r][c]);
          gy += KY[r][c] * int'(win[r][c]);
        end
      border  = (m_col == 0) || (m_col == H-1) || (m_row == 0) || (m_row == V-1);
      e.stamp = cyc + 3;
      e.g     = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      e.b     = !border && (e.g > m_thr);
      if (border) e.g = 0;
      sbq.push_back(e);
      if (e.b) m_cnt++;
      if (m_col == H-1 && m_row == V-1) begin
        fq.push_back('{cyc + 3, m_cnt});
        m_cnt = 0;
      end
      m_col++;
      if (m_col == H) begin m_col = 0; m_row = (m_row == V-1) ? 0 : m_row + 1; end
    end
    @(posedge clk); #1;
    clken = 1'b0;
    frame_sof = 1'b0;
  endtask

  task automatic set_win(input int kind);
    int f;
    f = $urandom_range(255);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        case (kind)
          0:       win[r][c] = (c == 0) ? 8'd0 : (c == 1) ? 8'd128 : 8'd255;
          1:       win[r][c] = 8'(f);
          default: win[r][c] = 8'($urandom_range(255));
        endcase
  endtask

  // kind<0 picks a random window type per pixel; npix<H*V stops mid-frame.
  task automatic run_frame(input int kind, input int sof_mode, input int gap_pct,
                           input bit pat, input int thr_chg_at, input int npix);
    int gaps;
    if (sof_mode == 1) issue(1'b0, 1'b1);
    for (int p = 0; p < npix; p++) begin
      gaps = 0;
      if (pat && p < 3) gaps = (p == 1) ? 2 : 0;
      else while ($urandom_range(99) < gap_pct && gaps < 4) gaps++;
      for (int g = 0; g < gaps; g++) issue(1'b0, 1'b0);
      if (p == thr_chg_at) thr = 11'd2047;
      set_win(kind < 0 ? int'($urandom_range(2)) : kind);
      issue(1'b1, (sof_mode == 2) && (p == 0));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || fq.size() != 0) && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL drain_timeout: %0d pixels and %0d frames outstanding, required 0",
               sbq.size(), fq.size());
      sbq.delete(); fq.delete();
    end
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b0);
  endtask

  exp_t me;
  frm_t mf;
  always @(negedge clk) if (rst_n) begin
    while (sbq.size() != 0 && sbq[0].stamp < cyc) begin
      me = sbq.pop_front();
      check("missing_output_stamp", -1, me.stamp);
    end
    while (fq.size() != 0 && fq[0].stamp < cyc) begin
      mf = fq.pop_front();
      check("missing_frame_done_stamp", -1, mf.stamp);
    end
    if (post_image_clken) begin
      if (sbq.size() == 0) check("unexpected_output", 1, 0);
      else begin
        me = sbq.pop_front();
        check("out_cycle", cyc, me.stamp);
        check("post_img_bit", int'(post_img_bit), int'(me.b));
        check("post_img_gray", int'(post_img_gray), me.b ? 255 : 0);
`ifdef SOBEL_GRAD_OUT_EN
        check("post_img_grad", int'(post_img_grad), me.g);
`endif
      end
    end
    if (frame_done) begin
      if (fq.size() == 0) check("unexpected_frame_done", 1, 0);
      else begin
        mf = fq.pop_front();
        check("frame_done_cycle", cyc, mf.stamp);
        check("edge_count_frame", int'(edge_count_frame), mf.cnt);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_clken"}, int'(post_image_clken), 0);
    check({tag, "_bit"}, int'(post_img_bit), 0);
    check({tag, "_gray"}, int'(post_img_gray), 0);
    check({tag, "_count"}, int'(edge_count_frame), 0);
    check({tag, "_done"}, int'(frame_done), 0);
  endtask

  initial begin
    set_win(1);
    #1;
    check_outputs_zero("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Step windows, strobe pattern 1,0,0,1,1 at start, thr=500.
    thr = 11'd500;
    run_frame(0, 1, 30, 1'b1, -1, H*V);
    drain();
    check("step_frame_count", int'(edge_count_frame), (H-2)*(V-2));

    // Mixed windows, sof coincident with first strobe, thr raised mid-frame (ignored).
    thr = 11'd0;
    run_frame(-1, 2, 25, 1'b0, 100, H*V);
    drain();

    // Random threshold, random windows, reset while pixels are in flight.
    thr = 11'($urandom_range(200, 1500));
    run_frame(2, 1, 20, 1'b0, -1, 90);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    sbq.delete(); fq.delete();
    m_col = 0; m_row = 0; m_cnt = 0; m_thr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1'b0, 1'b0);

    // No sof after reset: raster restarts at (0,0) with threshold 0.
    run_frame(-1, 0, 20, 1'b0, -1, H*V);
    drain();

    // Max threshold: no edges at all.
    thr = 11'd2047;
    run_frame(2, 1, 10, 1'b0, -1, H*V);
    drain();
    check("maxthr_frame_count", int'(edge_count_frame), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
